// File: rtl/mini_alu_16bit_div_pkg.sv
// Shared types and constants for the mini ALU sequential divider.
package mini_alu_16bit_div_pkg;

    // Operand and result width.
    localparam int WIDTH = 16;

    // Step counter width: must be able to count WIDTH steps.
    localparam int CNT_W = 5;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mini_alu_16bit_div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor if it fits and report the quotient bit.
module mini_alu_16bit_div_step
    import mini_alu_16bit_div_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W:0]   prem,
    input  logic         msb,
    input  logic [W-1:0] divisor,
    output logic [W:0]   prem_next,
    output logic         qbit
);

    logic [W+1:0] shifted;
    logic [W+1:0] divisor_ext;

    // Compare and conditionally subtract on a widened copy so the shifted
    // partial remainder never loses its top bit before the comparison.
    always_comb begin
        shifted     = {prem, msb};
        divisor_ext = {2'b00, divisor};
        qbit        = (shifted >= divisor_ext);
        if (qbit) begin
            prem_next = (W + 1)'(shifted - divisor_ext);
        end else begin
            prem_next = shifted[W:0];
        end
    end

endmodule

// File: rtl/mini_alu_16bit_div.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per clock.
// A start accepted in IDLE or DONE launches WIDTH steps; the result is held
// with valid high until the next accepted start.
module mini_alu_16bit_div
    import mini_alu_16bit_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   dividend_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic [WIDTH:0]     prem_reg;
    logic [WIDTH-1:0]   quot_reg;
    logic [WIDTH-1:0]   rem_reg;

    logic [WIDTH:0]     prem_step;
    logic               qbit_step;
    logic               accept;
    logic               last_step;

    // A request is taken whenever the divider is not iterating.
    assign accept    = start && (state_reg != BUSY);
    assign last_step = (state_reg == BUSY) && (cnt_reg == CNT_W'(WIDTH - 1));

    mini_alu_16bit_div_step #(
        .W (WIDTH)
    ) u_step (
        .prem      (prem_reg),
        .msb       (dividend_reg[WIDTH-1]),
        .divisor   (divisor_reg),
        .prem_next (prem_step),
        .qbit      (qbit_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept from IDLE/DONE, finish after the last step.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, iterate while busy, and load the
    // output registers only on the completion edge. The dividend register
    // doubles as the quotient shift register, so it holds the quotient once
    // all dividend bits have been shifted out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            prem_reg     <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
        end else if (accept) begin
            dividend_reg <= X;
            divisor_reg  <= Y;
            prem_reg     <= '0;
            cnt_reg      <= '0;
        end else if (state_reg == BUSY) begin
            prem_reg     <= prem_step;
            dividend_reg <= {dividend_reg[WIDTH-2:0], qbit_step};
            cnt_reg      <= cnt_reg + CNT_W'(1);
            if (last_step) begin
                quot_reg <= {dividend_reg[WIDTH-2:0], qbit_step};
                rem_reg  <= prem_step[WIDTH-1:0];
            end
        end
    end

    // Outputs come straight from registers; valid is the DONE state itself.
    assign valid = (state_reg == DONE);
    assign quot  = quot_reg;
    assign rem   = rem_reg;

endmodule

// File: tb/tb_mini_alu_16bit_div.sv
// Bench for the sequential divider: a table of directed vectors, random
// operand pairs, and hand-written sequences for held start, mid-operation
// start pulses and asynchronous reset aborts.
module tb_mini_alu_16bit_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] X;
    logic [15:0] Y;
    logic        valid;
    logic [15:0] quot;
    logic [15:0] rem;

    mini_alu_16bit_div dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .valid (valid),
        .quot  (quot),
        .rem   (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] q;
        logic [15:0] r;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          total;
    int          bad;
    logic [15:0] last_q;
    logic [15:0] last_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // Wait for completion after an accept edge; returns cycles until valid.
    task automatic wait_done(input logic pulse_mid, output int lat);
        lat = 0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            if (pulse_mid && c == 4) start = 1'b1;
            if (pulse_mid && c == 5) start = 1'b0;
            if (c == 8) begin
                chk("hold_quot_busy", {16'h0, quot}, {16'h0, last_q});
                chk("hold_rem_busy", {16'h0, rem}, {16'h0, last_r});
            end
            if (valid) begin
                lat = c;
                break;
            end
        end
    endtask

    // Pop the scoreboard and compare against the DUT result.
    task automatic compare_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("quot", {16'h0, quot}, {16'h0, e.q});
        chk("rem", {16'h0, rem}, {16'h0, e.r});
        $display("op %s: quot=%0d rem=%0d (exp %0d %0d)", tag, quot, rem, e.q, e.r);
        last_q = e.q;
        last_r = e.r;
    endtask

    // Full single-pulse operation: accept, scramble inputs, wait, check.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] eq, input logic [15:0] er,
                          input logic pulse_mid, input string tag);
        exp_t e;
        int   lat;
        @(negedge clk);
        X = x;
        Y = y;
        start = 1'b1;
        e.q = eq;
        e.r = er;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("valid_low_on_accept", {31'h0, valid}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        X = 16'($urandom);
        Y = 16'($urandom);
        wait_done(pulse_mid, lat);
        chk("latency", lat, 32'd16);
        compare_result(tag);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [15:0] rx;
        logic [15:0] ry;
        exp_t        e;

        total  = 0;
        bad    = 0;
        last_q = 16'h0;
        last_r = 16'h0;

        vecs[0] = '{x: 16'd15,    y: 16'd8,  q: 16'd1,     r: 16'd7};
        vecs[1] = '{x: 16'd10,    y: 16'd2,  q: 16'd5,     r: 16'd0};
        vecs[2] = '{x: 16'd89,    y: 16'd21, q: 16'd4,     r: 16'd5};
        vecs[3] = '{x: 16'd0,     y: 16'd20, q: 16'd0,     r: 16'd0};
        vecs[4] = '{x: 16'd77,    y: 16'd0,  q: 16'hFFFF,  r: 16'd77};
        vecs[5] = '{x: 16'd65535, y: 16'd1,  q: 16'd65535, r: 16'd0};

        rst   = 1'b0;
        start = 1'b0;
        X     = 16'h0;
        Y     = 16'h0;
        #12;
        chk("reset_valid", {31'h0, valid}, 32'd0);
        chk("reset_quot", {16'h0, quot}, 32'd0);
        chk("reset_rem", {16'h0, rem}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, 1'b0, $sformatf("vec%0d", i));
        end

        // Result stays held while idle in DONE.
        repeat (3) @(posedge clk);
        #1;
        chk("valid_held", {31'h0, valid}, 32'd1);
        chk("quot_held", {16'h0, quot}, {16'h0, last_q});

        // Start pulsed mid-operation is ignored.
        run_op(16'd1000, 16'd7, 16'd142, 16'd6, 1'b1, "mid_pulse");

        // Start held high: back-to-back operations, re-accepted at N+17.
        @(negedge clk);
        X = 16'd100;
        Y = 16'd9;
        start = 1'b1;
        e.q = 16'd11;
        e.r = 16'd1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("held_first_accept", {31'h0, valid}, 32'd0);
        wait_done(1'b0, lat);
        chk("held_latency1", lat, 32'd16);
        compare_result("held1");
        e.q = 16'd11;
        e.r = 16'd1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk("held_reaccept", {31'h0, valid}, 32'd0);
        start = 1'b0;
        wait_done(1'b0, lat);
        chk("held_latency2", lat, 32'd16);
        compare_result("held2");

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        X = 16'd500;
        Y = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_valid", {31'h0, valid}, 32'd0);
        chk("abort_quot", {16'h0, quot}, 32'd0);
        chk("abort_rem", {16'h0, rem}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1'b1;
        end
        chk("no_completion_after_abort", {31'h0, seen}, 32'd0);
        $display("op abort: valid stayed %0d", seen);
        last_q = 16'h0;
        last_r = 16'h0;

        // Random nonzero divisors.
        for (int i = 0; i < 10; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom_range(1, 65535));
            if (i < 3) ry = 16'($urandom_range(1, 20));
            run_op(rx, ry, rx / ry, rx % ry, 1'b0, $sformatf("rand%0d", i));
            chk("identity", 32'(quot) * 32'(ry) + 32'(rem), 32'(rx));
            chk("rem_lt_y", {31'h0, (rem < ry)}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
